// File: rtl/pattern_resp_misr.sv
// Response-capture stage: compacts qualified response samples into a MISR signature over a
// programmable window and reports response bits that never toggled during that window.
module pattern_resp_misr #(
  parameter int unsigned      RESP_W = 9,
  parameter int unsigned      SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021,
  parameter logic [SIG_W-1:0] SEED   = 16'h0000,
  parameter int unsigned      CNT_W  = 12
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              start,
  input  logic [CNT_W-1:0]  win_len,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_in,
  input  logic              sig_ack,
  output logic              busy,
  output logic              sig_valid,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [RESP_W-1:0] stuck_mask
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [RESP_W-1:0] seen0_q, seen0_d;
  logic [RESP_W-1:0] seen1_q, seen1_d;
  logic [RESP_W-1:0] mask_q, mask_d;
  logic [SIG_W-1:0]  resp_ext;

  always_comb begin
    resp_ext = '0;
    resp_ext[RESP_W-1:0] = resp_in;
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    seen0_d = seen0_q;
    seen1_d = seen1_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE, DONE: begin
        // start takes priority over sig_ack when both arrive in DONE
        if (start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          len_d   = win_len;
          seen0_d = '0;
          seen1_d = '0;
          if (win_len != '0) begin
            state_d = RUN;
            mask_d  = '0;
          end else begin
            state_d = DONE;
            mask_d  = '1;
          end
        end else if (state_q == DONE && sig_ack) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (resp_valid) begin
          sig_d   = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ resp_ext;
          cnt_d   = cnt_q + CNT_W'(1);
          seen0_d = seen0_q | ~resp_in;
          seen1_d = seen1_q | resp_in;
          if (cnt_q + CNT_W'(1) == len_q) begin
            state_d = DONE;
            mask_d  = ~(seen0_d & seen1_d);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      len_q   <= '0;
      seen0_q <= '0;
      seen1_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      seen0_q <= seen0_d;
      seen1_q <= seen1_d;
      mask_q  <= mask_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign sig_valid  = (state_q == DONE);
  assign signature  = sig_q;
  assign sample_cnt = cnt_q;
  assign stuck_mask = mask_q;

endmodule

// File: tb/tb_pattern_resp_misr.sv
// Self-checking bench for pattern_resp_misr: directed vector table, hand-written corner
// sequences and randomized windows compared against a queue-based signature model.
module tb_pattern_resp_misr;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] winLen;
  logic        respValid;
  logic [8:0]  respIn;
  logic        sigAck;
  logic        busy;
  logic        sigValid;
  logic [15:0] signature;
  logic [11:0] sampleCnt;
  logic [8:0]  stuckMask;

  int vectors;
  int miscompares;

  logic [8:0] samples[$];

  typedef struct {
    int          len;
    logic [8:0]  first;
    logic [8:0]  rest;
    logic [15:0] expSig;
    int          expCnt;
    logic [8:0]  expMask;
  } vec_t;

  vec_t vecTab[5];

  pattern_resp_misr dut (
    .blif_clk_net  (clk),
    .blif_reset_net(reset),
    .start         (start),
    .win_len       (winLen),
    .resp_valid    (respValid),
    .resp_in       (respIn),
    .sig_ack       (sigAck),
    .busy          (busy),
    .sig_valid     (sigValid),
    .signature     (signature),
    .sample_cnt    (sampleCnt),
    .stuck_mask    (stuckMask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Signature as polynomial division of the whole sample stream, starting from the seed
  function automatic logic [15:0] refSig();
    logic [15:0] s;
    s = 16'h0000;
    foreach (samples[i]) begin
      s = (s[15] ? 16'h1021 : 16'h0000) ^ (s << 1) ^ {7'd0, samples[i]};
    end
    return s;
  endfunction

  function automatic logic [8:0] refMask();
    logic [8:0] anyOne;
    logic [8:0] anyZero;
    anyOne  = '0;
    anyZero = '0;
    foreach (samples[i]) begin
      anyOne  = anyOne | samples[i];
      anyZero = anyZero | ~samples[i];
    end
    return ~(anyOne & anyZero);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input int len, input logic v,
                               input logic [8:0] r, input logic a);
    start     = s;
    winLen    = 12'(len);
    respValid = v;
    respIn    = r;
    sigAck    = a;
    tick();
    start     = 1'b0;
    respValid = 1'b0;
    sigAck    = 1'b0;
  endtask

  initial begin
    int   len;
    int   budget;
    logic v;
    logic [8:0] d;

    vectors     = 0;
    miscompares = 0;
    reset = 1'b1; start = 1'b0; winLen = '0; respValid = 1'b0; respIn = '0; sigAck = 1'b0;

    vecTab[0] = '{len: 1,  first: 9'h001, rest: 9'h000, expSig: 16'h0001, expCnt: 1,  expMask: 9'h1FF};
    vecTab[1] = '{len: 17, first: 9'h001, rest: 9'h000, expSig: 16'h1021, expCnt: 17, expMask: 9'h1FE};
    vecTab[2] = '{len: 0,  first: 9'h000, rest: 9'h000, expSig: 16'h0000, expCnt: 0,  expMask: 9'h1FF};
    vecTab[3] = '{len: 2,  first: 9'h1FF, rest: 9'h000, expSig: 16'h03FE, expCnt: 2,  expMask: 9'h000};
    vecTab[4] = '{len: 3,  first: 9'h155, rest: 9'h0AA, expSig: 16'h04AA, expCnt: 3,  expMask: 9'h000};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstSigValid", sigValid, 0);
    checkOutput("rstSig", signature, 16'h0000);
    checkOutput("rstCnt", sampleCnt, 0);
    checkOutput("rstMask", stuckMask, 0);
    reset = 1'b0;

    for (int t = 0; t < 5; t++) begin
      applyStimulus(1'b1, vecTab[t].len, 1'b0, 9'h000, 1'b0);
      checkOutput($sformatf("tab%0dBusy", t), busy, (vecTab[t].len != 0));
      for (int k = 0; k < vecTab[t].len; k++) begin
        if (k > 0) checkOutput($sformatf("tab%0dNotDone", t), sigValid, 0);
        applyStimulus(1'b0, 0, 1'b1, (k == 0) ? vecTab[t].first : vecTab[t].rest, 1'b0);
      end
      checkOutput($sformatf("tab%0dSigValid", t), sigValid, 1);
      checkOutput($sformatf("tab%0dSig", t), signature, vecTab[t].expSig);
      checkOutput($sformatf("tab%0dCnt", t), sampleCnt, vecTab[t].expCnt);
      checkOutput($sformatf("tab%0dMask", t), stuckMask, vecTab[t].expMask);
      applyStimulus(1'b0, 0, 1'b1, 9'h1AB, 1'b0);
      checkOutput($sformatf("tab%0dFrozen", t), signature, vecTab[t].expSig);
      applyStimulus(1'b0, 0, 1'b0, 9'h000, 1'b1);
      checkOutput($sformatf("tab%0dAckIdle", t), sigValid, 0);
      checkOutput($sformatf("tab%0dRetained", t), signature, vecTab[t].expSig);
    end

    // Window of 4 with resp_valid alternating; invalid cycles must not count
    samples.delete();
    applyStimulus(1'b1, 4, 1'b0, 9'h000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      v = (k % 2 == 0);
      d = 9'($urandom);
      if (v) samples.push_back(d);
      applyStimulus(1'b0, 0, v, d, 1'b0);
      checkOutput("altCnt", sampleCnt, samples.size());
      checkOutput("altSig", signature, refSig());
      if (k == 5) checkOutput("altBusyAfter3", busy, 1);
      if (k == 6) checkOutput("altDoneAfter4", sigValid, 1);
    end
    checkOutput("altMask", stuckMask, refMask());
    applyStimulus(1'b0, 0, 1'b0, 9'h000, 1'b1);

    // start during RUN and sig_ack outside DONE are ignored; start+ack in DONE restarts
    samples.delete();
    applyStimulus(1'b1, 5, 1'b0, 9'h000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      d = 9'($urandom);
      samples.push_back(d);
      applyStimulus(1'b0, 0, 1'b1, d, 1'b0);
    end
    applyStimulus(1'b1, 1, 1'b0, 9'h000, 1'b1);
    checkOutput("runStartBusy", busy, 1);
    checkOutput("runStartCnt", sampleCnt, 2);
    checkOutput("runStartSig", signature, refSig());
    for (int k = 0; k < 3; k++) begin
      d = 9'($urandom);
      samples.push_back(d);
      applyStimulus(1'b0, 0, 1'b1, d, 1'b0);
    end
    checkOutput("restartPreDone", sigValid, 1);
    checkOutput("restartPreSig", signature, refSig());
    applyStimulus(1'b1, 3, 1'b0, 9'h000, 1'b1);
    checkOutput("restartBusy", busy, 1);
    checkOutput("restartSig", signature, 16'h0000);
    checkOutput("restartCnt", sampleCnt, 0);

    // Reset asserted mid-window clears outputs without waiting for a clock edge
    applyStimulus(1'b0, 0, 1'b1, 9'h0F3, 1'b0);
    #3 reset = 1'b1;
    #1;
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstSig", signature, 16'h0000);
    checkOutput("midRstCnt", sampleCnt, 0);
    checkOutput("midRstSigValid", sigValid, 0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("postRstIdle", busy, 0);

    for (int w = 0; w < 30; w++) begin
      samples.delete();
      len = $urandom_range(1, 24);
      applyStimulus(1'b1, len, 1'b0, 9'h000, 1'b0);
      checkOutput("rndStartBusy", busy, 1);
      checkOutput("rndStartSig", signature, 16'h0000);
      budget = 0;
      while (samples.size() < len && budget < 200) begin
        v = ($urandom_range(0, 2) != 0);
        d = 9'($urandom);
        if (v) samples.push_back(d);
        applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 30), v, d,
                      $urandom_range(0, 7) == 0);
        budget++;
        checkOutput("rndSig", signature, refSig());
        checkOutput("rndCnt", sampleCnt, samples.size());
        checkOutput("rndSigValid", sigValid, (samples.size() == len));
      end
      if (samples.size() < len) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL rndTimeout: window %0d got %0d samples, expected %0d", w, samples.size(), len);
      end
      checkOutput("rndMask", stuckMask, refMask());
      applyStimulus(1'b0, 0, 1'b0, 9'h000, 1'b1);
      checkOutput("rndAckIdle", sigValid | busy, 0);
      checkOutput("rndRetained", signature, refSig());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
